timeline_player: RTL and testbench
==================================

# timeline_player

Programmable, parametrised frame-code sequencer for game animation scenes such as the end screen, intro and countdown. It holds a writable table of per-step scene codes and advances a step counter on divided-clock ticks at a programmable rate. Playback runs one-shot or looped, and the current code drives the display/scene mux. It replaces fixed per-scene counter-to-code lookups with a single runtime-loaded block.

## Interface
Parameters:
- STEP_W, 6: step index width.
- DEPTH, 64: table entries, at most 2^STEP_W.
- CODE_W, 4: scene code width.
- RATE_W, 4: rate field width.
- IDLE_CODE, 0: code output in IDLE.
- DEFAULT_CODE, 2: reset value of every table entry.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: one clock; reset is synchronous and active-low.
- tick, in, 1: 1-cycle pulse from the clock divider.
- start, in, 1: begin playback from step 0.
- stop, in, 1: abort to IDLE.
- loop_mode, in, 1: 1 = loop, 0 = one-shot; sampled at start.
- rate, in, RATE_W: steps advance every rate+1 ticks; sampled at start.
- last, in, STEP_W: final step index; sampled at start.
- wr_en, in, 1: table write strobe.
- wr_addr, in, STEP_W: table write address.
- wr_data, in, CODE_W: table write data.
- code, out, CODE_W: current scene code (registered).
- step, out, STEP_W: current step (registered).
- busy, out, 1: high in RUN.
- done, out, 1: 1-cycle pulse at one-shot completion.
- wrap, out, 1: 1-cycle pulse on loop wrap.

## Operation
- States: IDLE, RUN, DONE.
- Reset (rst_n low at a clk edge):
  - state = IDLE; step = 0; code = IDLE_CODE.
  - busy, done and wrap = 0; prescaler = 0.
  - All table entries = DEFAULT_CODE.
- Control priority per cycle: stop > start > tick.
- IDLE:
  - code = IDLE_CODE; step = 0.
  - start → RUN. Latches rate, loop_mode and last; step = 0; prescaler = 0.
- RUN, on tick:
  - If prescaler == latched rate: prescaler = 0 and the step advances.
  - Otherwise prescaler increments.
- Step advance:
  - step < last: step + 1.
  - step == last, loop: step = 0 and wrap pulses.
  - step == last, one-shot: state = DONE, done pulses, step holds last.
- DONE: step holds last; code holds table[last]; busy = 0. start → RUN as from IDLE.
- start while in RUN restarts from step 0 with freshly latched parameters. done and wrap do not pulse.
- stop in any state → IDLE next cycle; the prescaler clears.
- last clamp: latched last ≥ DEPTH is treated as DEPTH-1.
- last = 0:
  - One-shot enters DONE on the first advance.
  - Loop pulses wrap on every advance.
- Table writes:
  - Accepted in any state; wr_addr ≥ DEPTH is ignored.
  - A write is visible to code reads from the next cycle onward.
- Inputs changed during RUN have no effect until the next start: rate, last, loop_mode.

## Timing
- step, busy, done and wrap update on the clk edge that samples the causing start, tick or stop.
- code lags step by one cycle: in RUN/DONE, code at cycle N+1 = table[step at cycle N].
- On entering IDLE, code = IDLE_CODE one cycle after the stop edge.
- With rate = r and a tick every cycle, the step period is r+1 cycles.
- First advance happens r+1 ticks after start. Ticks coincident with start are not counted.
- done and wrap are high for exactly one clk cycle, coincident with the step update.
- busy rises the cycle after start is sampled and falls with done or stop.
- Reset mid-playback takes priority over all inputs and restores the reset values above.

## Structure
- Package timeline_pkg:
  - State enum {IDLE, RUN, DONE}.
  - Default parameter constants.
  - Named scene-code constants shared with the display mux.
- Sub-module step_prescaler:
  - RATE_W-bit tick counter with clear, load and terminal-count output.
  - Instantiated once; timeline_player owns the FSM, the table and the step logic.

## Test plan
- Reset value check: reset, then load table[0..5] = 0,0,1,2,3,4 with rate = 0, last = 5, one-shot, tick every cycle, start.
  - Required: step 0→5 on consecutive cycles.
  - Required: code sequence 0,0,1,2,3,4 lagging step by one.
  - Required: done pulses once and busy falls; code holds 4 in DONE.
  - Also required: entries 6..63 read back as 2.
- Loop and rate: rate = 2, last = 3, loop, tick every cycle.
  - Required: step changes every 3 cycles, order 0,1,2,3,0.
  - Required: wrap pulses at 3→0 and done never asserts.
- Clamp and mid-run change: last = 63 with DEPTH = 40.
  - Required: playback ends at step 39.
  - Changing last or rate mid-run has no effect.
- Control collisions:
  - stop and start in the same cycle during RUN → IDLE, code = 0.
  - start during RUN at step 7 → step 0, no done or wrap pulse.
- Reset mid-run: drop rst_n at step 10.
  - Required: step = 0, code = 0, busy = 0 next cycle.
  - Required: the whole table reads back as 2.
- Live write: during a loop, write table[2] = 9 while step = 1.
  - Required: code = 9 one cycle after step reaches 2.
  - Required: a write to wr_addr = 50 with DEPTH = 40 changes nothing.

Source files
------------

// File: rtl/timeline_pkg.sv
// ============================================================================
//  Module      : timeline_pkg
//  Description : Shared FSM states, default sizes and scene codes for the
//                timeline player and the display/scene mux.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package timeline_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int c_default_step_w = 6;
    localparam int c_default_depth  = 64;
    localparam int c_default_code_w = 4;
    localparam int c_default_rate_w = 4;

    // Scene codes understood by the display mux
    localparam logic [3:0] c_scene_blank     = 4'd0;
    localparam logic [3:0] c_scene_intro     = 4'd1;
    localparam logic [3:0] c_scene_play      = 4'd2;
    localparam logic [3:0] c_scene_countdown = 4'd3;
    localparam logic [3:0] c_scene_end       = 4'd4;

endpackage

`default_nettype wire

// File: rtl/step_prescaler.sv
// ============================================================================
//  Module      : step_prescaler
//  Description : Tick counter that raises tc on the tick that completes a
//                rate+1 tick period; clear/load restart the period.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module step_prescaler #(
    parameter int RATE_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [RATE_W-1:0] rate,
    input  logic              tick,
    output logic              tc
);

    logic [RATE_W-1:0] r_rate;
    logic [RATE_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
            r_rate  <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= '0;
            r_rate  <= rate;
        end else if (tick) begin
            r_count <= (r_count == r_rate) ? '0 : r_count + 1'b1;
        end
    end

    // Ticks coincident with clear/load never complete a period
    assign tc = tick && !clear && !load && (r_count == r_rate);

endmodule

`default_nettype wire

// File: rtl/timeline_player.sv
// ============================================================================
//  Module      : timeline_player
//  Description : Runtime-loadable scene-code sequencer stepping through a
//                code table at a programmable tick rate, one-shot or looped.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module timeline_player
    import timeline_pkg::*;
#(
    parameter int                STEP_W       = c_default_step_w,
    parameter int                DEPTH        = c_default_depth,
    parameter int                CODE_W       = c_default_code_w,
    parameter int                RATE_W       = c_default_rate_w,
    parameter logic [CODE_W-1:0] IDLE_CODE    = CODE_W'(c_scene_blank),
    parameter logic [CODE_W-1:0] DEFAULT_CODE = CODE_W'(c_scene_play)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_mode,
    input  logic [RATE_W-1:0] rate,
    input  logic [STEP_W-1:0] last,
    input  logic              wr_en,
    input  logic [STEP_W-1:0] wr_addr,
    input  logic [CODE_W-1:0] wr_data,
    output logic [CODE_W-1:0] code,
    output logic [STEP_W-1:0] step,
    output logic              busy,
    output logic              done,
    output logic              wrap
);

    state_t              r_state;
    state_t              w_state_next;
    logic [STEP_W-1:0]   w_step_next;
    logic                w_done_next;
    logic                w_wrap_next;
    logic [STEP_W-1:0]   r_last;
    logic [STEP_W-1:0]   w_last_clamped;
    logic                r_loop;
    logic                w_tc;
    logic [CODE_W-1:0]   r_table [DEPTH];

    assign w_last_clamped = ({1'b0, last} >= (STEP_W+1)'(DEPTH)) ? STEP_W'(DEPTH - 1) : last;

    step_prescaler #(
        .RATE_W (RATE_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (stop),
        .load  (start),
        .rate  (rate),
        .tick  (tick && (r_state == RUN)),
        .tc    (w_tc)
    );

    // Addresses with no matching entry fall through, so out-of-range writes are dropped
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_table
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_table[i] <= DEFAULT_CODE;
                end else if (wr_en && (wr_addr == STEP_W'(i))) begin
                    r_table[i] <= wr_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            step    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wrap    <= 1'b0;
            r_last  <= '0;
            r_loop  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            step    <= w_step_next;
            busy    <= (w_state_next == RUN);
            done    <= w_done_next;
            wrap    <= w_wrap_next;
            if (start && !stop) begin
                r_last <= w_last_clamped;
                r_loop <= loop_mode;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_step_next  = step;
        w_done_next  = 1'b0;
        w_wrap_next  = 1'b0;
        if (stop) begin
            w_state_next = IDLE;
            w_step_next  = '0;
        end else if (start) begin
            w_state_next = RUN;
            w_step_next  = '0;
        end else begin
            case (r_state)
                IDLE: w_step_next = '0;
                RUN: begin
                    if (w_tc) begin
                        if (step < r_last) begin
                            w_step_next = step + 1'b1;
                        end else if (r_loop) begin
                            w_step_next = '0;
                            w_wrap_next = 1'b1;
                        end else begin
                            w_state_next = DONE;
                            w_done_next  = 1'b1;
                        end
                    end
                end
                DONE:    w_step_next  = step;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Code trails step by one cycle and reads the table as it stood before this edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code <= IDLE_CODE;
        end else if (r_state == IDLE) begin
            code <= IDLE_CODE;
        end else begin
            code <= r_table[step];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_timeline_player.sv
// ============================================================================
//  Module      : tb_timeline_player
//  Description : Vector table, directed corner sequences and randomized run
//                against a behavioural model of the timeline player.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_timeline_player;

    localparam int STEP_W       = 6;
    localparam int DEPTH        = 40;
    localparam int CODE_W       = 4;
    localparam int RATE_W       = 4;
    localparam int IDLE_CODE    = 0;
    localparam int DEFAULT_CODE = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              tick;
    logic              start;
    logic              stop;
    logic              loop_mode;
    logic [RATE_W-1:0] rate;
    logic [STEP_W-1:0] last;
    logic              wr_en;
    logic [STEP_W-1:0] wr_addr;
    logic [CODE_W-1:0] wr_data;
    logic [CODE_W-1:0] code;
    logic [STEP_W-1:0] step;
    logic              busy;
    logic              done;
    logic              wrap;

    always #5 clk = ~clk;

    timeline_player #(
        .STEP_W       (STEP_W),
        .DEPTH        (DEPTH),
        .CODE_W       (CODE_W),
        .RATE_W       (RATE_W),
        .IDLE_CODE    (4'(IDLE_CODE)),
        .DEFAULT_CODE (4'(DEFAULT_CODE))
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .start     (start),
        .stop      (stop),
        .loop_mode (loop_mode),
        .rate      (rate),
        .last      (last),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .code      (code),
        .step      (step),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: playback described as "ticks counted since last advance"
    int m_table [DEPTH];
    bit m_running, m_finished, m_loop, m_done, m_wrap;
    int m_step, m_ticks, m_rate, m_last, m_code;

    function automatic void model_edge();
        int nc;
        if (!rst_n) begin
            foreach (m_table[i]) m_table[i] = DEFAULT_CODE;
            m_running = 0; m_finished = 0; m_step = 0; m_ticks = 0;
            m_code = IDLE_CODE; m_done = 0; m_wrap = 0;
        end else begin
            nc = (m_running || m_finished) ? m_table[m_step] : IDLE_CODE;
            m_done = 0;
            m_wrap = 0;
            if (wr_en && int'(wr_addr) < DEPTH) m_table[wr_addr] = int'(wr_data);
            if (stop) begin
                m_running = 0; m_finished = 0; m_step = 0; m_ticks = 0;
            end else if (start) begin
                m_running = 1; m_finished = 0; m_step = 0; m_ticks = 0;
                m_rate = int'(rate);
                m_loop = loop_mode;
                m_last = (int'(last) >= DEPTH) ? DEPTH - 1 : int'(last);
            end else if (m_running && tick) begin
                m_ticks++;
                if (m_ticks == m_rate + 1) begin
                    m_ticks = 0;
                    if (m_step < m_last) m_step++;
                    else if (m_loop) begin m_step = 0; m_wrap = 1; end
                    else begin m_running = 0; m_finished = 1; m_done = 1; end
                end
            end
            m_code = nc;
        end
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_model(string tag);
        chk({tag, ".step"}, int'(step), m_step);
        chk({tag, ".code"}, int'(code), m_code);
        chk({tag, ".busy"}, int'(busy), int'(m_running));
        chk({tag, ".done"}, int'(done), int'(m_done));
        chk({tag, ".wrap"}, int'(wrap), int'(m_wrap));
    endtask

    task automatic quiet();
        tick = 1'b0; start = 1'b0; stop = 1'b0; loop_mode = 1'b0;
        rate = '0; last = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    endtask

    // One-shot full-table playback at rate 0; last=63 clamps to DEPTH-1
    task automatic readback(bit all_default);
        start = 1'b1; stop = 1'b0; rate = '0; last = 6'd63; loop_mode = 1'b0; tick = 1'b1;
        cycle();
        start = 1'b0;
        for (int k = 1; k <= 41; k++) begin
            cycle();
            chk_model("readback");
            if (all_default) chk("readback.default", int'(code), DEFAULT_CODE);
        end
    endtask

    typedef struct {
        int tick, start, loop_m, rate, last, we, wa, wd;
        int e_step, e_code, e_busy, e_done, e_wrap;
    } vec_t;

    vec_t vecs [15];
    int   init_codes [6] = '{0, 0, 1, 2, 3, 4};

    initial begin
        int ci;

        quiet();
        rst_n = 1'b0;
        cycle();
        cycle();
        chk("reset.step", int'(step), 0);
        chk("reset.code", int'(code), IDLE_CODE);
        chk("reset.busy", int'(busy), 0);
        chk("reset.done", int'(done), 0);
        chk("reset.wrap", int'(wrap), 0);
        rst_n = 1'b1;

        // Load table[0..5], then one-shot rate 0 to last 5
        for (int i = 0; i < 6; i++)
            vecs[i] = '{0, 0, 0, 0, 0, 1, i, init_codes[i], 0, 0, 0, 0, 0};
        vecs[6]  = '{1, 1, 0, 0, 5, 0, 0, 0, 0, 0, 1, 0, 0};
        vecs[7]  = '{1, 0, 0, 0, 5, 0, 0, 0, 1, 0, 1, 0, 0};
        vecs[8]  = '{1, 0, 0, 0, 5, 0, 0, 0, 2, 0, 1, 0, 0};
        vecs[9]  = '{1, 0, 0, 0, 5, 0, 0, 0, 3, 1, 1, 0, 0};
        vecs[10] = '{1, 0, 0, 0, 5, 0, 0, 0, 4, 2, 1, 0, 0};
        vecs[11] = '{1, 0, 0, 0, 5, 0, 0, 0, 5, 3, 1, 0, 0};
        vecs[12] = '{1, 0, 0, 0, 5, 0, 0, 0, 5, 4, 0, 1, 0};
        vecs[13] = '{1, 0, 0, 0, 5, 0, 0, 0, 5, 4, 0, 0, 0};
        vecs[14] = '{1, 0, 0, 0, 5, 0, 0, 0, 5, 4, 0, 0, 0};
        for (int i = 0; i < 15; i++) begin
            tick      = vecs[i].tick[0];
            start     = vecs[i].start[0];
            loop_mode = vecs[i].loop_m[0];
            rate      = vecs[i].rate[RATE_W-1:0];
            last      = vecs[i].last[STEP_W-1:0];
            wr_en     = vecs[i].we[0];
            wr_addr   = vecs[i].wa[STEP_W-1:0];
            wr_data   = vecs[i].wd[CODE_W-1:0];
            cycle();
            chk($sformatf("vec%0d.step", i), int'(step), vecs[i].e_step);
            chk($sformatf("vec%0d.code", i), int'(code), vecs[i].e_code);
            chk($sformatf("vec%0d.busy", i), int'(busy), vecs[i].e_busy);
            chk($sformatf("vec%0d.done", i), int'(done), vecs[i].e_done);
            chk($sformatf("vec%0d.wrap", i), int'(wrap), vecs[i].e_wrap);
        end
        quiet();

        // Clamp to step 39, defaults beyond entry 5, mid-run parameter changes ignored
        start = 1'b1; rate = '0; last = 6'd63; loop_mode = 1'b0; tick = 1'b1;
        cycle();
        start = 1'b0;
        for (int k = 1; k <= 41; k++) begin
            if (k == 10) begin last = 6'd3; rate = 4'd5; loop_mode = 1'b1; end
            cycle();
            ci = (k - 1 > 39) ? 39 : k - 1;
            chk($sformatf("clamp%0d.step", k), int'(step), (k < 39) ? k : 39);
            chk($sformatf("clamp%0d.code", k), int'(code), (ci < 6) ? init_codes[ci] : DEFAULT_CODE);
            chk($sformatf("clamp%0d.done", k), int'(done), (k == 40) ? 1 : 0);
            chk($sformatf("clamp%0d.busy", k), int'(busy), (k < 40) ? 1 : 0);
        end
        quiet();

        // Loop at rate 2 with a live write and an out-of-range write
        start = 1'b1; rate = 4'd2; last = 6'd3; loop_mode = 1'b1; tick = 1'b1;
        cycle();
        start = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            wr_en   = (k == 4 || k == 5);
            wr_addr = (k == 4) ? 6'd2 : 6'd50;
            wr_data = (k == 4) ? 4'd9 : 4'd7;
            cycle();
            chk($sformatf("loop%0d.step", k), int'(step), (k / 3) % 4);
            chk($sformatf("loop%0d.wrap", k), int'(wrap), (k == 12) ? 1 : 0);
            chk($sformatf("loop%0d.done", k), int'(done), 0);
            if (k == 7) chk("loop.livewrite", int'(code), 9);
            chk_model("loop");
        end
        wr_en = 1'b0;
        readback(1'b0);
        quiet();

        // Restart at step 7, then stop+start collision
        start = 1'b1; rate = '0; last = 6'd20; tick = 1'b1;
        cycle();
        start = 1'b0;
        repeat (7) cycle();
        chk("coll.step7", int'(step), 7);
        start = 1'b1;
        cycle();
        chk("restart.step", int'(step), 0);
        chk("restart.busy", int'(busy), 1);
        chk("restart.done", int'(done), 0);
        chk("restart.wrap", int'(wrap), 0);
        start = 1'b0;
        repeat (3) cycle();
        stop = 1'b1; start = 1'b1;
        cycle();
        chk("stopstart.busy", int'(busy), 0);
        chk("stopstart.step", int'(step), 0);
        stop = 1'b0; start = 1'b0;
        cycle();
        chk("stopstart.code", int'(code), IDLE_CODE);
        chk("stopstart.busy2", int'(busy), 0);
        chk("stopstart.step2", int'(step), 0);

        // Reset mid-run restores table defaults
        start = 1'b1; last = 6'd39;
        cycle();
        start = 1'b0;
        repeat (10) cycle();
        chk("midrst.step10", int'(step), 10);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("midrst.step", int'(step), 0);
        chk("midrst.code", int'(code), IDLE_CODE);
        chk("midrst.busy", int'(busy), 0);
        readback(1'b1);
        quiet();

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            tick      = 1'($urandom_range(0, 1));
            start     = ($urandom_range(0, 19) == 0);
            stop      = ($urandom_range(0, 39) == 0);
            loop_mode = 1'($urandom_range(0, 1));
            rate      = 4'($urandom_range(0, 3));
            last      = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
            wr_en     = ($urandom_range(0, 3) == 0);
            wr_addr   = 6'($urandom_range(0, 63));
            wr_data   = 4'($urandom_range(0, 15));
            cycle();
            chk_model($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
